// File: rtl/ag_issue_ctrl_if.sv
// Decode/AG1/AG2/writeback signal bundle for the AG1 issue controller.
// The master modport drives decode, backpressure, writeback and flush; the slave is the controller.
interface ag_issue_ctrl_if #(
    parameter int unsigned NREG = 8
);
    localparam int unsigned RW = $clog2(NREG);

    logic          dec_valid;
    logic          dec_ready;
    logic [RW-1:0] dec_sr1;
    logic [RW-1:0] dec_sr2;
    logic          dec_use_sr1;
    logic          dec_use_sr2;
    logic [RW-1:0] dec_dr;
    logic          dec_wr_dr;
    logic          dec_far_jmp;
    logic          dec_isO1Mem;
    logic          ag2_ready;
    logic          wb_valid;
    logic [RW-1:0] wb_dr;
    logic          flush;
    logic          ag_ld;
    logic          ag_valid;
    logic          ag_beat;
    logic          ag_inc4;
    logic [NREG-1:0] sb_busy;

    modport master (
        output dec_valid, dec_sr1, dec_sr2, dec_use_sr1, dec_use_sr2,
               dec_dr, dec_wr_dr, dec_far_jmp, dec_isO1Mem,
               ag2_ready, wb_valid, wb_dr, flush,
        input  dec_ready, ag_ld, ag_valid, ag_beat, ag_inc4, sb_busy
    );

    modport slave (
        input  dec_valid, dec_sr1, dec_sr2, dec_use_sr1, dec_use_sr2,
               dec_dr, dec_wr_dr, dec_far_jmp, dec_isO1Mem,
               ag2_ready, wb_valid, wb_dr, flush,
        output dec_ready, ag_ld, ag_valid, ag_beat, ag_inc4, sb_busy
    );
endinterface

// File: rtl/ag_issue_ctrl.sv
// AG1 issue controller: scoreboard hazard check, AG1 latch load/valid control with
// AG2 backpressure, and two-beat sequencing for far jumps with a memory operand.
module ag_issue_ctrl #(
    parameter int unsigned NREG = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    ag_issue_ctrl_if.slave       io
);
    typedef enum logic {RUN, FAR2} state_e;

    state_e          state_q, state_d;
    logic            ag_valid_q, ag_valid_d;
    logic            ag_beat_q, ag_beat_d;
    logic [NREG-1:0] sb_busy_q, sb_busy_d;

    logic hazard;
    logic free;
    logic accept;
    logic far_load;

    always_comb begin
        hazard = (io.dec_use_sr1 & sb_busy_q[io.dec_sr1]) |
                 (io.dec_use_sr2 & sb_busy_q[io.dec_sr2]);
        free   = ~ag_valid_q | io.ag2_ready;

        io.dec_ready = rst & (state_q == RUN) & ~hazard & free & ~io.flush;
        accept       = io.dec_valid & io.dec_ready;
        far_load     = rst & ~io.flush & (state_q == FAR2) & free;
        io.ag_ld     = accept | far_load;

        state_d    = state_q;
        ag_valid_d = ag_valid_q;
        ag_beat_d  = ag_beat_q;
        sb_busy_d  = sb_busy_q;

        if (io.ag2_ready) begin
            ag_valid_d = 1'b0;
            ag_beat_d  = 1'b0;
        end

        if (accept) begin
            ag_valid_d = 1'b1;
            ag_beat_d  = 1'b0;
            if (io.dec_far_jmp && io.dec_isO1Mem) begin
                state_d = FAR2;
            end
        end else if (far_load) begin
            ag_valid_d = 1'b1;
            ag_beat_d  = 1'b1;
            state_d    = RUN;
        end

        // Clear before set so an accepted writer beats a same-index writeback.
        if (io.wb_valid) begin
            sb_busy_d[io.wb_dr] = 1'b0;
        end
        if (accept && io.dec_wr_dr) begin
            sb_busy_d[io.dec_dr] = 1'b1;
        end

        if (io.flush) begin
            state_d    = RUN;
            ag_valid_d = 1'b0;
            ag_beat_d  = 1'b0;
            sb_busy_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= RUN;
            ag_valid_q <= 1'b0;
            ag_beat_q  <= 1'b0;
            sb_busy_q  <= '0;
        end else begin
            state_q    <= state_d;
            ag_valid_q <= ag_valid_d;
            ag_beat_q  <= ag_beat_d;
            sb_busy_q  <= sb_busy_d;
        end
    end

    assign io.ag_valid = ag_valid_q;
    assign io.ag_beat  = ag_beat_q;
    assign io.ag_inc4  = ag_beat_q;
    assign io.sb_busy  = sb_busy_q;
endmodule

// File: tb/tb_ag_issue_ctrl.sv
// Directed-vector bench for ag_issue_ctrl with hand-computed expectations.
module tb_ag_issue_ctrl;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    ag_issue_ctrl_if #(.NREG(8)) bus ();

    ag_issue_ctrl #(.NREG(8)) dut (
        .clk (clk),
        .rst (rst),
        .io  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dec(input logic v, input logic [2:0] sr1, input logic u1,
                       input logic [2:0] sr2, input logic u2,
                       input logic [2:0] dr, input logic wr,
                       input logic far, input logic mem);
        bus.dec_valid   = v;
        bus.dec_sr1     = sr1;
        bus.dec_use_sr1 = u1;
        bus.dec_sr2     = sr2;
        bus.dec_use_sr2 = u2;
        bus.dec_dr      = dr;
        bus.dec_wr_dr   = wr;
        bus.dec_far_jmp = far;
        bus.dec_isO1Mem = mem;
    endtask

    // Far jump FAR2 entry with sb_busy=8'h24, used by both the flush and reset abort tests.
    task automatic setup_far2();
        bus.ag2_ready = 1'b1;
        dec(1, 0, 0, 0, 0, 3'd2, 1, 0, 0); tick();
        dec(1, 0, 0, 0, 0, 3'd5, 1, 0, 0); tick();
        dec(1, 0, 0, 0, 0, 3'd0, 0, 1, 1);
        #1 check("abort_far_accept", bus.dec_ready, 1);
        tick();
        dec(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("abort_sb24", bus.sb_busy, 8'h24);
        check("abort_beat0", bus.ag_beat, 0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        dec(0, 0, 0, 0, 0, 0, 0, 0, 0);
        bus.ag2_ready = 1'b1;
        bus.wb_valid  = 1'b0;
        bus.wb_dr     = '0;
        bus.flush     = 1'b0;

        // Reset: combinational outputs forced low even with a ready-looking request.
        rst = 1'b0;
        tick();
        dec(1, 1, 1, 2, 1, 0, 0, 0, 0);
        #1;
        check("rst_dec_ready", bus.dec_ready, 0);
        check("rst_ag_ld", bus.ag_ld, 0);
        tick();
        check("rst_ag_valid", bus.ag_valid, 0);
        check("rst_ag_beat", bus.ag_beat, 0);
        check("rst_ag_inc4", bus.ag_inc4, 0);
        check("rst_sb_busy", bus.sb_busy, 0);
        dec(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        tick();

        // Back-to-back independent issue.
        for (int i = 0; i < 4; i++) begin
            dec(1, 1, 1, 2, 1, 0, 0, 0, 0);
            #1;
            check("b2b_dec_ready", bus.dec_ready, 1);
            check("b2b_ag_ld", bus.ag_ld, 1);
            tick();
            check("b2b_ag_valid", bus.ag_valid, 1);
            check("b2b_ag_beat", bus.ag_beat, 0);
        end
        dec(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        check("b2b_drain", bus.ag_valid, 0);

        // RAW stall on r3, released the cycle after writeback.
        dec(1, 0, 0, 0, 0, 3'd3, 1, 0, 0);
        tick();
        check("raw_sb08", bus.sb_busy, 8'h08);
        dec(1, 3'd3, 0, 3'd4, 1, 0, 0, 0, 0);
        #1 check("raw_unused_src", bus.dec_ready, 1);
        dec(1, 3'd3, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            #1 check("raw_stall", bus.dec_ready, 0);
            tick();
        end
        dec(1, 0, 0, 3'd3, 1, 0, 0, 0, 0);
        #1 check("raw_stall_sr2", bus.dec_ready, 0);
        bus.wb_valid = 1'b1;
        bus.wb_dr    = 3'd3;
        #1 check("raw_no_bypass", bus.dec_ready, 0);
        tick();
        bus.wb_valid = 1'b0;
        check("raw_sb_clear", bus.sb_busy, 0);
        #1 check("raw_release", bus.dec_ready, 1);
        tick();
        check("raw_b_valid", bus.ag_valid, 1);
        dec(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();

        // Far memory jump with 2 cycles of backpressure on beat 0.
        dec(1, 0, 0, 0, 0, 0, 0, 1, 1);
        #1 check("far_accept", bus.dec_ready, 1);
        tick();
        check("far_b0_valid", bus.ag_valid, 1);
        check("far_b0_beat", bus.ag_beat, 0);
        dec(1, 1, 1, 2, 1, 0, 0, 0, 0);
        bus.ag2_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("far_hold_ready", bus.dec_ready, 0);
            check("far_hold_ld", bus.ag_ld, 0);
            tick();
            check("far_hold_beat", bus.ag_beat, 0);
            check("far_hold_valid", bus.ag_valid, 1);
        end
        bus.ag2_ready = 1'b1;
        #1;
        check("far_b1_ld", bus.ag_ld, 1);
        check("far_b1_ready", bus.dec_ready, 0);
        tick();
        check("far_b1_beat", bus.ag_beat, 1);
        check("far_b1_inc4", bus.ag_inc4, 1);
        check("far_b1_valid", bus.ag_valid, 1);
        #1 check("far_next_ready", bus.dec_ready, 1);
        tick();
        check("far_next_beat", bus.ag_beat, 0);

        // Backpressure with a waiting instruction.
        bus.ag2_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_ready", bus.dec_ready, 0);
            check("bp_ld", bus.ag_ld, 0);
            tick();
            check("bp_valid", bus.ag_valid, 1);
            check("bp_beat", bus.ag_beat, 0);
        end
        bus.ag2_ready = 1'b1;
        #1 check("bp_accept", bus.dec_ready, 1);
        tick();
        dec(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();

        // Simultaneous set/clear of r5: set wins; a lone clear then frees it.
        dec(1, 0, 0, 0, 0, 3'd5, 1, 0, 0);
        tick();
        check("sc_set", bus.sb_busy, 8'h20);
        bus.wb_valid = 1'b1;
        bus.wb_dr    = 3'd5;
        tick();
        check("sc_set_wins", bus.sb_busy, 8'h20);
        dec(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        bus.wb_valid = 1'b0;
        check("sc_clear", bus.sb_busy, 0);
        tick();

        // Flush in FAR2: selector beat dropped, state back to RUN.
        setup_far2();
        bus.flush = 1'b1;
        #1;
        check("fl_ld", bus.ag_ld, 0);
        check("fl_ready", bus.dec_ready, 0);
        tick();
        bus.flush = 1'b0;
        check("fl_valid", bus.ag_valid, 0);
        check("fl_beat", bus.ag_beat, 0);
        check("fl_sb", bus.sb_busy, 0);
        #1;
        check("fl_no_sel", bus.ag_ld, 0);
        check("fl_run", bus.dec_ready, 1);
        tick();
        check("fl_stay_idle", bus.ag_valid, 0);

        // Reset in FAR2 instead of flush.
        setup_far2();
        rst = 1'b0;
        #1 check("rs_ld", bus.ag_ld, 0);
        tick();
        rst = 1'b1;
        check("rs_valid", bus.ag_valid, 0);
        check("rs_beat", bus.ag_beat, 0);
        check("rs_sb", bus.sb_busy, 0);
        #1;
        check("rs_no_sel", bus.ag_ld, 0);
        check("rs_run", bus.dec_ready, 1);
        tick();
        check("rs_stay_idle", bus.ag_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/ag_issue_ctrl.md
# ag_issue_ctrl

Issue controller for the address-generation stage-1 pipeline latches. It accepts decoded instructions from decode and checks source registers against an 8-entry register scoreboard. It drives the load enable and valid bit of the AG1 latches and applies backpressure from AG2. A far jump with a memory operand needs two address-generation beats (32-bit offset at the address, 16-bit selector at address+4), and this block sequences both beats.

## Interface
Parameters:
- NREG, 8, architectural GPR count; scoreboard depth; register index is log2(NREG) = 3 bits.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; **one clock; reset is synchronous and active-low.**
- dec_valid  in  1  decode presents an instruction.
- dec_ready  out  1  controller accepts this cycle; combinational.
- dec_sr1, dec_sr2  in  3 each  source register indices.
- dec_use_sr1, dec_use_sr2  in  1 each  the source is actually read.
- dec_dr  in  3  destination register.
- dec_wr_dr  in  1  instruction writes dec_dr.
- dec_far_jmp  in  1  far jump.
- dec_isO1Mem  in  1  operand 1 is memory.
- ag2_ready  in  1  AG2 consumes the AG1 latch contents this cycle.
- wb_valid  in  1  register writeback this cycle.
- wb_dr  in  3  writeback register.
- flush  in  1  kill everything at and before AG1.
- ag_ld  out  1  load enable for AG1 latches; combinational.
- ag_valid  out  1  AG1 latch holds a live beat; registered.
- ag_beat  out  1  0 = first/only beat, 1 = far-pointer selector beat; registered.
- ag_inc4  out  1  AG1 address adds +4 (selector beat); registered, equals ag_beat.
- sb_busy  out  NREG  scoreboard busy bits; registered.

## Operation
- FSM states: RUN, FAR2.
- Hazard: (dec_use_sr1 & sb_busy[dec_sr1]) | (dec_use_sr2 & sb_busy[dec_sr2]).
  - No same-cycle writeback bypass: a bit cleared by wb_valid is seen clear only from the next cycle.
- Slot free: free = ~ag_valid | ag2_ready.
- dec_ready = (state==RUN) & ~hazard & free & ~flush.
- Accept = dec_valid & dec_ready. On accept:
  - ag_ld=1, ag_valid<=1, ag_beat<=0.
  - If dec_far_jmp & dec_isO1Mem: state<=FAR2.
- FAR2:
  - dec_ready=0.
  - When free: ag_ld=1, ag_valid<=1, ag_beat<=1, state<=RUN.
  - Otherwise hold.
- No new beat loaded and ag2_ready=1: ag_valid<=0.
- ag_valid=1 and ag2_ready=0: ag_valid, ag_beat and latches hold, with ag_ld=0.
- Scoreboard:
  - On accept with dec_wr_dr: sb_busy[dec_dr]<=1.
  - On wb_valid: sb_busy[wb_dr]<=0.
  - Set and clear of the same index in one cycle: set wins (younger writer).
  - A far jump sets at most once, on beat 0.
- flush has top priority:
  - ag_ld=0.
  - Next cycle: ag_valid=0, ag_beat=0, state=RUN, sb_busy=0.
  - Flush is only asserted when no older writer remains beyond AG1.
- Reset wins over flush.

## Timing
- Reset values (rst=0 at an edge): state=RUN, ag_valid=0, ag_beat=0, ag_inc4=0, sb_busy=0.
  - Combinational outputs during reset: dec_ready and ag_ld are forced 0 while rst=0.
- Latency: accept in cycle N gives ag_valid=1 in N+1.
- Far memory jump: beat 0 in N+1, beat 1 in N+2 at the earliest (if ag2_ready=1 in N+1). The next instruction accepts in N+2 at the earliest.
- Throughput: one beat per cycle when ag2_ready is held 1.
- Hazard release: wb_valid in cycle W allows accept in W+1 at the earliest.
- Reset or flush mid-FAR2: the selector beat is dropped, and FAR2 is abandoned.

## Test plan
- Back-to-back issue:
  - Stimulus: 4 independent instructions (sr1=1, sr2=2, no busy), ag2_ready=1.
  - Required: dec_ready=1 each cycle, ag_valid=1 for 4 consecutive cycles from N+1, ag_beat=0 throughout.
- RAW stall:
  - Stimulus: instr A writes dr=3, then B with use_sr1, sr1=3. wb_valid with wb_dr=3 in cycle 5.
  - Required: sb_busy=8'h08 after A. B stalls (dec_ready=0) through cycle 5 and accepts in cycle 6. sb_busy=0 at cycle 6.
- Far memory jump:
  - Stimulus: dec_far_jmp=1, isO1Mem=1, ag2_ready=0 for 2 cycles after accept, then 1.
  - Required: beat 0 holds for 2 cycles. Beat 1 loads with ag_inc4=1 on the cycle ag2_ready rises. dec_ready=0 until the cycle after beat 1 loads.
- Backpressure:
  - Stimulus: ag_valid=1, ag2_ready=0 for 3 cycles, dec_valid=1.
  - Required: dec_ready=0, ag_ld=0, outputs stable. Accept on the first cycle ag2_ready=1.
- Simultaneous set/clear:
  - Stimulus: accept writer with dr=5 in the same cycle as wb_valid, wb_dr=5.
  - Required: sb_busy[5]=1 afterwards.
- Flush/reset mid-sequence:
  - Stimulus: flush in the FAR2 cycle with sb_busy=8'h24, then a separate test with rst=0 in the same position.
  - Required: next cycle ag_valid=0, state RUN, sb_busy=0, no selector beat issued.
